// File: rtl/instr_fetcher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetcher_pkg
// Description : Shared types and helpers for the per-SIMD instruction
//               fetcher: fetch state encoding and context-index width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } fetch_state_e;

    // Context index width; a single-wave SIMD still carries a 1-bit index.
    function automatic int ctx_w(input int waves);
        return (waves > 1) ? $clog2(waves) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetcher_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetcher_if
// Description : Bundles the fetcher's PC-side request, wave dispatch,
//               program-memory and decode-side handshakes.
// Ports       : slave modport  - fetcher view
//               master modport - environment (PC/scheduler, memory, decode)
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetcher_if
    import instr_fetcher_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_WIDTH = 32,
    parameter int PROGRAM_MEM_DATA_WIDTH = 32,
    parameter int WAVES_PER_SIMD         = 1
);
    localparam int CTX_W = ctx_w(WAVES_PER_SIMD);

    // PC / scheduler side
    logic                              fetch_req;
    logic [CTX_W-1:0]                  fetch_ctx;
    logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc_in;
    logic                              fetch_ready;
    logic                              new_wave;
    logic [CTX_W-1:0]                  new_wave_ctx;
    logic                              pc_advance;
    // Program memory side
    logic                              mem_read_valid;
    logic [PROGRAM_MEM_ADDR_WIDTH-1:0] mem_read_address;
    logic                              mem_read_ready;
    logic                              mem_resp_valid;
    logic [PROGRAM_MEM_DATA_WIDTH-1:0] mem_resp_data;
    // Decode side
    logic                              instr_valid;
    logic [PROGRAM_MEM_DATA_WIDTH-1:0] instr;
    logic [CTX_W-1:0]                  instr_ctx;
    logic [PROGRAM_MEM_ADDR_WIDTH-1:0] instr_pc;
    logic                              instr_ready;

    modport slave (
        input  fetch_req, fetch_ctx, pc_in, new_wave, new_wave_ctx,
               mem_read_ready, mem_resp_valid, mem_resp_data, instr_ready,
        output fetch_ready, pc_advance, mem_read_valid, mem_read_address,
               instr_valid, instr, instr_ctx, instr_pc
    );

    modport master (
        output fetch_req, fetch_ctx, pc_in, new_wave, new_wave_ctx,
               mem_read_ready, mem_resp_valid, mem_resp_data, instr_ready,
        input  fetch_ready, pc_advance, mem_read_valid, mem_read_address,
               instr_valid, instr, instr_ctx, instr_pc
    );

endinterface
`default_nettype wire

// File: rtl/instr_fetcher_buffer.sv
`default_nettype none
// ============================================================================
// Module      : instr_buffer
// Description : One-entry instruction buffer per wave context (valid, PC
//               tag, instruction word). Combinational lookup, one write
//               port and one invalidate port; invalidate beats write when
//               both target the same context in the same cycle.
// Ports       : clk, rst (sync, active-low)
//               lookup_ctx_i/lookup_tag_i -> lookup_hit_o/lookup_data_o
//               wr_en_i/wr_ctx_i/wr_tag_i/wr_data_i
//               inv_en_i/inv_ctx_i
// Revision    : 1.0 - initial release
// ============================================================================
module instr_buffer
    import instr_fetcher_pkg::*;
#(
    parameter  int ADDR_WIDTH     = 32,
    parameter  int DATA_WIDTH     = 32,
    parameter  int WAVES_PER_SIMD = 1,
    localparam int CTX_W          = ctx_w(WAVES_PER_SIMD)
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic [CTX_W-1:0]      lookup_ctx_i,
    input  wire logic [ADDR_WIDTH-1:0] lookup_tag_i,
    output logic                       lookup_hit_o,
    output logic [DATA_WIDTH-1:0]      lookup_data_o,
    input  wire logic                  wr_en_i,
    input  wire logic [CTX_W-1:0]      wr_ctx_i,
    input  wire logic [ADDR_WIDTH-1:0] wr_tag_i,
    input  wire logic [DATA_WIDTH-1:0] wr_data_i,
    input  wire logic                  inv_en_i,
    input  wire logic [CTX_W-1:0]      inv_ctx_i
);

    logic [WAVES_PER_SIMD-1:0] hit_vec;
    logic [DATA_WIDTH-1:0]     data_vec [WAVES_PER_SIMD];

    for (genvar g = 0; g < WAVES_PER_SIMD; g++) begin : g_entry
        logic                  valid_q;
        logic [ADDR_WIDTH-1:0] tag_q;
        logic [DATA_WIDTH-1:0] data_q;
        logic                  wr_sel;
        logic                  inv_sel;

        assign wr_sel  = wr_en_i  && (wr_ctx_i  == CTX_W'(g));
        assign inv_sel = inv_en_i && (inv_ctx_i == CTX_W'(g));

        always_ff @(posedge clk) begin
            if (!rst) begin
                valid_q <= 1'b0;
                tag_q   <= '0;
                data_q  <= '0;
            end else if (inv_sel) begin
                valid_q <= 1'b0;
            end else if (wr_sel) begin
                valid_q <= 1'b1;
                tag_q   <= wr_tag_i;
                data_q  <= wr_data_i;
            end
        end

        assign hit_vec[g]  = valid_q && (tag_q == lookup_tag_i) &&
                             (lookup_ctx_i == CTX_W'(g));
        assign data_vec[g] = data_q;
    end

    // At most one entry can match the looked-up context, so OR-ing the
    // qualified data words acts as the read mux.
    always_comb begin
        lookup_data_o = '0;
        for (int i = 0; i < WAVES_PER_SIMD; i++) begin
            if (hit_vec[i]) begin
                lookup_data_o = lookup_data_o | data_vec[i];
            end
        end
    end

    assign lookup_hit_o = |hit_vec;

endmodule
`default_nettype wire

// File: rtl/instr_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetcher
// Description : Per-SIMD instruction fetcher. Takes the active wave's PC,
//               serves the instruction from a per-context one-entry buffer
//               or program memory, presents it to decode and pulses
//               pc_advance when decode consumes it.
// Ports       : clk, rst (sync, active-low)
//               bus (instr_fetcher_if.slave): fetch request, wave dispatch,
//               program memory request/response, decode handshake
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetcher
    import instr_fetcher_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_WIDTH = 32,
    parameter int PROGRAM_MEM_DATA_WIDTH = 32,
    parameter int WAVES_PER_SIMD         = 1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    instr_fetcher_if.slave bus
);

    localparam int CTX_W = ctx_w(WAVES_PER_SIMD);

    fetch_state_e                      state_q, state_d;
    logic [CTX_W-1:0]                  ctx_q, ctx_d;
    logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [PROGRAM_MEM_DATA_WIDTH-1:0] data_q, data_d;
    logic                              flush_q, flush_d;

    logic                              lookup_hit;
    logic [PROGRAM_MEM_DATA_WIDTH-1:0] lookup_data;
    logic                              buf_wr_en;
    logic                              inflight_kill;
    logic                              fetch_kill;

    // The wave owning the in-flight fetch was re-dispatched this cycle.
    assign inflight_kill = bus.new_wave && (bus.new_wave_ctx == ctx_q) &&
                           (state_q != ST_IDLE);
    // Same-cycle re-dispatch of the requesting wave: its entry is being
    // invalidated, so a lookup hit must not be trusted.
    assign fetch_kill    = bus.new_wave && (bus.new_wave_ctx == bus.fetch_ctx);

    instr_buffer #(
        .ADDR_WIDTH     (PROGRAM_MEM_ADDR_WIDTH),
        .DATA_WIDTH     (PROGRAM_MEM_DATA_WIDTH),
        .WAVES_PER_SIMD (WAVES_PER_SIMD)
    ) u_buffer (
        .clk           (clk),
        .rst           (rst),
        .lookup_ctx_i  (bus.fetch_ctx),
        .lookup_tag_i  (bus.pc_in),
        .lookup_hit_o  (lookup_hit),
        .lookup_data_o (lookup_data),
        .wr_en_i       (buf_wr_en),
        .wr_ctx_i      (ctx_q),
        .wr_tag_i      (pc_q),
        .wr_data_i     (bus.mem_resp_data),
        .inv_en_i      (bus.new_wave),
        .inv_ctx_i     (bus.new_wave_ctx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ctx_q   <= '0;
            pc_q    <= '0;
            data_q  <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctx_q   <= ctx_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ctx_d     = ctx_q;
        pc_d      = pc_q;
        data_d    = data_q;
        flush_d   = flush_q || inflight_kill;
        buf_wr_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                flush_d = 1'b0;
                if (bus.fetch_req) begin
                    ctx_d = bus.fetch_ctx;
                    pc_d  = bus.pc_in;
                    if (lookup_hit && !fetch_kill) begin
                        data_d  = lookup_data;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // A flush here still finishes the memory handshake; the
                // response is dropped in WAIT via the pending-flush flag.
                if (bus.mem_read_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_resp_valid) begin
                    if (flush_d) begin
                        flush_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        buf_wr_en = 1'b1;
                        data_d    = bus.mem_resp_data;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                flush_d = 1'b0;
                if (inflight_kill || bus.instr_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.fetch_ready      = (state_q == ST_IDLE);
    assign bus.mem_read_valid   = (state_q == ST_REQ);
    assign bus.mem_read_address = pc_q;
    assign bus.instr_valid      = (state_q == ST_DONE);
    assign bus.instr            = data_q;
    assign bus.instr_ctx        = ctx_q;
    assign bus.instr_pc         = pc_q;
    assign bus.pc_advance       = bus.instr_valid && bus.instr_ready;

endmodule
`default_nettype wire

// File: doc/instr_fetcher.md
# instr_fetcher

- Per-SIMD instruction fetcher. It takes the active wave's PC from the per-SIMD program counter, returns the instruction at that address to the decode/issue stage, and pulses the program counter's UPDATE_PC input when the instruction is consumed.
- It holds a one-entry instruction buffer per wave context, so a resumed wave whose PC has not moved is served without a memory access.
- It sits between the PC block, program memory and decode.

## Interface
- PROGRAM_MEM_ADDR_WIDTH, 32, program memory address width; equals PC width.
- PROGRAM_MEM_DATA_WIDTH, 32, instruction width.
- WAVES_PER_SIMD, 1, wave contexts per SIMD; CTX_W = max(1, clog2(WAVES_PER_SIMD)).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- fetch_req  in  1  request a fetch for fetch_ctx at pc_in.
- fetch_ctx  in  CTX_W  requesting wave context.
- pc_in  in  PROGRAM_MEM_ADDR_WIDTH  PC of fetch_ctx; valid whenever fetch_req is high.
- fetch_ready  out  1  combinational; high in IDLE.
- new_wave  in  1  wave dispatched into new_wave_ctx (same pulse as PC's DISPATCH_NEW_WAVE).
- new_wave_ctx  in  CTX_W  context being re-dispatched.
- mem_read_valid  out  1  program memory read request.
- mem_read_address  out  PROGRAM_MEM_ADDR_WIDTH  read address.
- mem_read_ready  in  1  memory accepts request this cycle.
- mem_resp_valid  in  1  read data valid, single-cycle pulse.
- mem_resp_data  in  PROGRAM_MEM_DATA_WIDTH  read data.
- instr_valid  out  1  instruction available to decode.
- instr  out  PROGRAM_MEM_DATA_WIDTH  instruction.
- instr_ctx  out  CTX_W  owning context.
- instr_pc  out  PROGRAM_MEM_ADDR_WIDTH  address of instr.
- instr_ready  in  1  decode consumes instr.
- pc_advance  out  1  combinational; instr_valid && instr_ready; drives UPDATE_PC.

## Operation
- **States:**
  - IDLE: fetch_ready=1.
  - REQ: mem_read_valid=1.
  - WAIT: awaiting response.
  - DONE: instr_valid=1.
- **Buffer entry per context:** valid, tag (PC) and data.
- **IDLE, fetch_req high:** latch ctx and pc_in.
  - Hit (entry valid and tag==pc_in): go to DONE with the buffer data.
  - Miss: go to REQ.
  - fetch_req outside IDLE is ignored.
- **REQ:** mem_read_address = latched PC.
  - If mem_read_ready is high: go to WAIT.
  - Otherwise hold; valid and address stay stable.
- **WAIT:** on mem_resp_valid, capture the data and write the buffer entry (valid=1, tag=PC), then go to DONE. mem_resp_valid is ignored in every other state.
- **DONE:** instr, instr_ctx and instr_pc stay stable until instr_ready. On the handshake, pc_advance=1 for that cycle and the next state is IDLE.
- **new_wave:** clears valid of entry new_wave_ctx.
  - If the in-flight ctx equals new_wave_ctx:
    - In REQ: complete the memory handshake, then discard.
    - In WAIT: discard the response; no buffer write, no instr_valid; return to IDLE.
    - In DONE: drop instr_valid next cycle and return to IDLE with no pc_advance.
  - A pending-flush flag tracks this case.
  - new_wave and fetch_req in the same cycle for the same ctx: the invalidate takes effect first, so the result is a miss.
- **Reset (rst=0), at any time:**
  - State returns to IDLE and all entries are invalidated.
  - Registered outputs go to 0: mem_read_valid, mem_read_address, instr_valid, instr, instr_ctx, instr_pc.
  - fetch_req is ignored while rst=0.
  - A response arriving after reset lands in IDLE and is ignored.

## Timing
- **Hit:** fetch_req in cycle t; instr_valid in t+1.
- **Miss:**
  - mem_read_valid in t+1.
  - With ready at t+1 and response at t+1+L, instr_valid in t+2+L.
  - The earliest response is the cycle after request acceptance.
- **pc_advance at t:** the PC updates at the end of t, and the fetcher is in IDLE at t+1 with the new pc_in. Back-to-back fetch is therefore allowed at t+1.
- **Scheduler obligation:** hold active_context for at least 1 cycle before fetch_req, because pc_out lags a context switch by one cycle.
- **Buffer write:** takes effect at the end of the capture cycle.
- **PC arithmetic:** addresses are used as-is; no increment is done here. PC wrap-around is the PC's concern.

## Structure
- **Shared package:** state enum (IDLE, REQ, WAIT, DONE) and the CTX_W function.
- **Sub-module `instr_buffer`:** per-context valid/tag/data array.
  - One lookup port (combinational).
  - One write port.
  - One invalidate port.
  - When write and invalidate target the same ctx, invalidate wins.

## Test plan
- Cold miss, ctx0, pc_in=0x0: mem_read_address=0x0; ready at t+1; resp 0xDEADBEEF at t+3 -> instr=0xDEADBEEF, instr_pc=0, instr_valid at t+4; pc_advance with instr_ready.
- Hit, WAVES_PER_SIMD=2: ctx1 fetch pc=5 (miss), switch to ctx0, back to ctx1 pc=5 -> instr_valid at t+1, mem_read_valid never asserted.
- Backpressure: mem_read_ready low 3 cycles, then instr_ready low 4 cycles -> address and instr stable; exactly one pc_advance.
- Flush: new_wave on the same ctx during WAIT -> response discarded, no instr_valid; next fetch of same pc misses.
- Same-cycle new_wave and fetch_req on a hit ctx -> memory read issued.
- Reset in DONE and in WAIT -> IDLE, all outputs 0; a late mem_resp_valid produces no instr_valid; a previously buffered PC misses.
